tmds_lane_scheduler: RTL and testbench



---
 rtl/tmds_pkg.sv | 20 ++
 rtl/tmds_stage_buf.sv | 39 +++
 rtl/tmds_lane_scheduler.sv | 128 ++++++++++++
 tb/tb_tmds_lane_scheduler.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS constants and the lane-scheduler state encoding.
package tmds_pkg;

   localparam int unsigned BITS_PER_WORD = 10;

   localparam logic [9:0] TMDS_CTRL_00 = 10'h354;
   localparam logic [9:0] TMDS_CTRL_01 = 10'h0AB;
   localparam logic [9:0] TMDS_CTRL_10 = 10'h154;
   localparam logic [9:0] TMDS_CTRL_11 = 10'h2AB;

   localparam logic [9:0] TMDS_CLK_PATTERN = 10'b0000011111;
   localparam logic [9:0] TMDS_IDLE        = TMDS_CTRL_00;

   typedef enum logic [1:0] {
      ST_WARMUP,
      ST_RUN,
      ST_DISABLED
   } sched_state_t;

endpackage

// File: rtl/tmds_stage_buf.sv
// One-entry staging register for a 30-bit symbol triple with valid/ready, pop and flush.
module tmds_stage_buf (
   input  logic        clk,
   input  logic        rst,
   input  logic        accept_en,
   input  logic        pop,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [29:0] in_data,
   output logic        full,
   output logic [29:0] data
);

   logic take;

   // A pop frees the entry in the same cycle, so capture and pop can coincide.
   assign in_ready = accept_en && (!full || pop);
   assign take     = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         full <= 1'b0;
      end else if (take) begin
         full <= 1'b1;
      end else if (pop) begin
         full <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data <= '0;
      end else if (take) begin
         data <= in_data;
      end
   end

endmodule

// File: rtl/tmds_lane_scheduler.sv
// Word-boundary scheduler for the three TMDS data lanes and the clock lane,
// including warm-up, underflow substitution and serializer sync reset.
module tmds_lane_scheduler #(
   parameter int unsigned IDLE_WORDS = 16,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [9:0]       in_d0,
   input  logic [9:0]       in_d1,
   input  logic [9:0]       in_d2,
   output logic [9:0]       word_d0,
   output logic [9:0]       word_d1,
   output logic [9:0]       word_d2,
   output logic [9:0]       clk_word,
   output logic [3:0]       bit_idx,
   output logic             word_strobe,
   output logic             ser_rst,
   output logic             running,
   output logic [CNT_W-1:0] underflow_cnt
);
   import tmds_pkg::*;

   sched_state_t state_q, state_d;
   logic [15:0]  warm_cnt;
   logic         boundary;
   logic         warm_inc;
   logic         load_stage;
   logic         uf_inc;
   logic         flush;
   logic         stage_full;
   logic [29:0]  stage_data;

   assign boundary    = (bit_idx == 4'(BITS_PER_WORD - 1));
   assign word_strobe = boundary;
   assign running     = (state_q == ST_RUN);
   assign clk_word    = TMDS_CLK_PATTERN;

   tmds_stage_buf u_stage (
      .clk       (clk),
      .rst       (rst),
      .accept_en (running),
      .pop       (boundary && running),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   ({in_d2, in_d1, in_d0}),
      .full      (stage_full),
      .data      (stage_data)
   );

   always_comb begin
      state_d    = state_q;
      warm_inc   = 1'b0;
      load_stage = 1'b0;
      uf_inc     = 1'b0;
      flush      = (state_q != ST_RUN);
      case (state_q)
         ST_WARMUP: begin
            if (boundary) begin
               warm_inc = 1'b1;
               if (warm_cnt == 16'(IDLE_WORDS - 1)) begin
                  state_d = enable ? ST_RUN : ST_DISABLED;
               end
            end
         end
         ST_RUN: begin
            if (boundary) begin
               if (stage_full) begin
                  load_stage = 1'b1;
               end else begin
                  uf_inc = 1'b1;
               end
               // The final RUN load completes before the stage is discarded.
               if (!enable) begin
                  state_d = ST_DISABLED;
                  flush   = 1'b1;
               end
            end
         end
         ST_DISABLED: begin
            if (boundary && enable) begin
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_WARMUP;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_WARMUP;
         warm_cnt      <= '0;
         bit_idx       <= '0;
         ser_rst       <= 1'b1;
         word_d0       <= TMDS_IDLE;
         word_d1       <= TMDS_IDLE;
         word_d2       <= TMDS_IDLE;
         underflow_cnt <= '0;
      end else begin
         state_q <= state_d;
         bit_idx <= boundary ? 4'd0 : bit_idx + 4'd1;
         // Serializer loads index 9 on this edge, then both counters wrap together.
         if (bit_idx == 4'(BITS_PER_WORD - 2)) begin
            ser_rst <= 1'b0;
         end
         if (warm_inc) begin
            warm_cnt <= warm_cnt + 16'd1;
         end
         if (boundary) begin
            if (load_stage) begin
               {word_d2, word_d1, word_d0} <= stage_data;
            end else begin
               word_d0 <= TMDS_IDLE;
               word_d1 <= TMDS_IDLE;
               word_d2 <= TMDS_IDLE;
            end
         end
         if (uf_inc && (underflow_cnt != '1)) begin
            underflow_cnt <= underflow_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_tmds_lane_scheduler.sv
// Directed bench for tmds_lane_scheduler with a scoreboard of accepted triples.
module tb_tmds_lane_scheduler;
   import tmds_pkg::*;

   localparam logic [29:0] IDLE3 = {TMDS_CTRL_00, TMDS_CTRL_00, TMDS_CTRL_00};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b1;
   logic        in_valid = 1'b0;
   logic [9:0]  in_d0 = '0, in_d1 = '0, in_d2 = '0;

   logic        in_ready, word_strobe, ser_rst, running;
   logic [9:0]  word_d0, word_d1, word_d2, clk_word;
   logic [3:0]  bit_idx;
   logic [15:0] underflow_cnt;

   logic        s_in_ready, s_word_strobe, s_ser_rst, s_running;
   logic [9:0]  s_word_d0, s_word_d1, s_word_d2, s_clk_word;
   logic [3:0]  s_bit_idx;
   logic [1:0]  s_underflow_cnt;

   logic [29:0] word3;
   logic [29:0] sb[$];
   int          errors = 0;
   int          checks = 0;

   assign word3 = {word_d2, word_d1, word_d0};

   always #5 clk = ~clk;

   tmds_lane_scheduler #(.IDLE_WORDS(4), .CNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
      .in_d0(in_d0), .in_d1(in_d1), .in_d2(in_d2),
      .word_d0(word_d0), .word_d1(word_d1), .word_d2(word_d2), .clk_word(clk_word),
      .bit_idx(bit_idx), .word_strobe(word_strobe), .ser_rst(ser_rst),
      .running(running), .underflow_cnt(underflow_cnt)
   );

   tmds_lane_scheduler #(.IDLE_WORDS(4), .CNT_W(2)) u_sat (
      .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_ready(s_in_ready),
      .in_d0(in_d0), .in_d1(in_d1), .in_d2(in_d2),
      .word_d0(s_word_d0), .word_d1(s_word_d1), .word_d2(s_word_d2), .clk_word(s_clk_word),
      .bit_idx(s_bit_idx), .word_strobe(s_word_strobe), .ser_rst(s_ser_rst),
      .running(s_running), .underflow_cnt(s_underflow_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one bit clock; record accepted triples and check each new non-idle word.
   task automatic tick();
      logic [29:0] exp;
      if (in_valid && in_ready) sb.push_back({in_d2, in_d1, in_d0});
      @(posedge clk);
      #1;
      if (bit_idx == 4'd0 && word3 != IDLE3) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected_word", 32'(word3), 32'(IDLE3));
         end else begin
            exp = sb.pop_front();
            chk("sb_word", 32'(word3), 32'(exp));
         end
      end
   endtask

   task automatic check_warmup(input string tag);
      for (int i = 0; i < 40; i++) begin
         chk({tag, "_bit_idx"}, 32'(bit_idx), 32'(i % 10));
         chk({tag, "_strobe"}, 32'(word_strobe), 32'((i % 10) == 9));
         chk({tag, "_ser_rst"}, 32'(ser_rst), 32'(i < 9));
         chk({tag, "_word_idle"}, 32'(word3), 32'(IDLE3));
         chk({tag, "_running"}, 32'(running), 32'd0);
         chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
         tick();
      end
      chk({tag, "_run_rise"}, 32'(running), 32'd1);
      chk({tag, "_ready_rise"}, 32'(in_ready), 32'd1);
      chk({tag, "_bit_idx_wrap"}, 32'(bit_idx), 32'd0);
   endtask

   initial begin
      int waits;

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_bit_idx", 32'(bit_idx), 32'd0);
      chk("rst_word", 32'(word3), 32'(IDLE3));
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_running", 32'(running), 32'd0);
      chk("rst_ser_rst", 32'(ser_rst), 32'd1);
      chk("rst_uf", 32'(underflow_cnt), 32'd0);
      chk("rst_uf_sat", 32'(s_underflow_cnt), 32'd0);
      chk("clk_word", 32'(clk_word), 32'h01F);
      rst = 1'b0;

      check_warmup("warm1");

      in_d0 = 10'h2CC; in_d1 = 10'h133; in_d2 = 10'h0F0; in_valid = 1'b1;
      chk("t1_ready", 32'(in_ready), 32'd1);
      tick();
      in_d0 = 10'h0A5; in_d1 = 10'h15A; in_d2 = 10'h3C3;
      for (int i = 1; i < 9; i++) begin
         chk("t2_ready_low", 32'(in_ready), 32'd0);
         tick();
      end
      chk("t2_ready_boundary", 32'(in_ready), 32'd1);
      tick();
      chk("t1_word_d0", 32'(word_d0), 32'h2CC);
      chk("t1_word_d1", 32'(word_d1), 32'h133);
      chk("t1_word_d2", 32'(word_d2), 32'h0F0);
      chk("t1_uf", 32'(underflow_cnt), 32'd0);

      for (int k = 0; k < 100; k++) begin
         in_d0 = 10'(k + 1); in_d1 = 10'(k * 37); in_d2 = 10'(1000 - k);
         waits = 0;
         while (!in_ready && waits < 20) begin
            tick();
            waits++;
         end
         chk("stream_ready_gap", 32'(waits), 32'd9);
         if (waits >= 20) break;
         tick();
      end
      in_valid = 1'b0;
      chk("stream_uf", 32'(underflow_cnt), 32'd0);

      repeat (10) tick();
      chk("drain_last_word", 32'(word3), 32'({10'(1000 - 99), 10'(99 * 37), 10'(100)}));
      for (int w = 1; w <= 5; w++) begin
         repeat (10) tick();
         chk("uf_word_idle", 32'(word3), 32'(IDLE3));
         chk("uf_cnt", 32'(underflow_cnt), 32'(w));
         chk("uf_cnt_sat", 32'(s_underflow_cnt), 32'((w < 3) ? w : 3));
      end

      in_d0 = 10'h111; in_d1 = 10'h222; in_d2 = 10'h099; in_valid = 1'b1;
      chk("dis_ready", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      enable = 1'b0;
      repeat (4) tick();
      chk("dis_midword_running", 32'(running), 32'd1);
      chk("dis_midword_ready", 32'(in_ready), 32'd0);
      repeat (5) tick();
      chk("dis_staged_word", 32'(word3), 32'({10'h099, 10'h222, 10'h111}));
      chk("dis_running", 32'(running), 32'd0);
      for (int i = 0; i < 10; i++) begin
         chk("dis_ready_low", 32'(in_ready), 32'd0);
         tick();
      end
      chk("dis_idle_word", 32'(word3), 32'(IDLE3));
      chk("dis_uf_hold", 32'(underflow_cnt), 32'd5);
      enable = 1'b1;
      repeat (10) tick();
      chk("reen_running", 32'(running), 32'd1);
      chk("reen_idle_word", 32'(word3), 32'(IDLE3));
      chk("reen_ready", 32'(in_ready), 32'd1);
      in_d0 = 10'h3E1; in_d1 = 10'h01E; in_d2 = 10'h2D2; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (9) tick();
      chk("reen_word", 32'(word3), 32'({10'h2D2, 10'h01E, 10'h3E1}));
      chk("reen_uf", 32'(underflow_cnt), 32'd5);

      repeat (5) tick();
      chk("mid_rst_bit_idx_pre", 32'(bit_idx), 32'd5);
      rst = 1'b1;
      tick();
      chk("mid_rst_bit_idx", 32'(bit_idx), 32'd0);
      chk("mid_rst_word", 32'(word3), 32'(IDLE3));
      chk("mid_rst_ser_rst", 32'(ser_rst), 32'd1);
      chk("mid_rst_uf", 32'(underflow_cnt), 32'd0);
      chk("mid_rst_uf_sat", 32'(s_underflow_cnt), 32'd0);
      chk("mid_rst_running", 32'(running), 32'd0);
      rst = 1'b0;
      check_warmup("warm2");

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
